// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: circular byte buffer with top-of-queue linear address tracking.
// Optional `PREFETCH_BYPASS_EN: an empty queue forwards the incoming byte straight to prefetchTop.
module prefetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BUS_BYTES  = 1,
    parameter logic [19:0] RESET_ADDR = 20'hFFFF0
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic                       wrValid,
    input  logic [8*BUS_BYTES-1:0]     wrData,
    input  logic                       wrOddStart,
    input  logic                       advanceTop,
    input  logic                       flush,
    input  logic [19:0]                flushAddr,
    output logic [7:0]                 prefetchTop,
    output logic [19:0]                prefetchTopLinearAddress,
    output logic                       prefetchEmpty,
    output logic                       prefetchFull,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] BB_L    = LW'(BUS_BYTES);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [7:0]    buffer [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [19:0]   top_addr;

    logic [15:0]   data_pad;
    logic [7:0]    first_byte;
    logic [1:0]    n_bytes;
    logic          wr_accept;
    logic          pop_stored;
    logic          bypass_active;
    logic          bypass_pop;
    logic [1:0]    store_cnt;
    logic [7:0]    store_b0;
    logic [7:0]    store_b1;
    logic [PW-1:0] wr_ptr_p1;
    logic [PW-1:0] wr_ptr_p2;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [LW-1:0] level_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        data_pad = '0;
        data_pad[8*BUS_BYTES-1:0] = wrData;
        if (BUS_BYTES == 2 && wrOddStart) begin
            first_byte = data_pad[15:8];
            n_bytes    = 2'd1;
        end else begin
            first_byte = data_pad[7:0];
            n_bytes    = (BUS_BYTES == 2) ? 2'd2 : 2'd1;
        end
    end

    assign prefetchFull = (DEPTH_L - level) < BB_L;
    assign wr_accept    = wrValid && !prefetchFull && !flush;
    assign pop_stored   = advanceTop && (level != '0) && !flush;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_active = (level == '0) && wr_accept;
`else
    assign bypass_active = 1'b0;
`endif
    assign bypass_pop = bypass_active && advanceTop;

    // A bypass-consumed byte is never stored; only the remaining byte (if any) lands in the buffer.
    always_comb begin
        store_b1 = data_pad[15:8];
        if (bypass_pop) begin
            store_b0  = data_pad[15:8];
            store_cnt = n_bytes - 2'd1;
        end else begin
            store_b0  = first_byte;
            store_cnt = n_bytes;
        end
        if (!wr_accept) begin
            store_cnt = 2'd0;
        end
    end

    always_comb begin
        wr_ptr_p1 = ptr_inc(wr_ptr);
        wr_ptr_p2 = ptr_inc(wr_ptr_p1);
        case (store_cnt)
            2'd1:    wr_ptr_next = wr_ptr_p1;
            2'd2:    wr_ptr_next = wr_ptr_p2;
            default: wr_ptr_next = wr_ptr;
        endcase
        rd_ptr_next = pop_stored ? ptr_inc(rd_ptr) : rd_ptr;
        level_next  = level + LW'(store_cnt) - LW'(pop_stored);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            top_addr <= RESET_ADDR;
        end else if (flush) begin
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            top_addr <= flushAddr;
        end else begin
            level  <= level_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            if (pop_stored || bypass_pop) begin
                top_addr <= top_addr + 20'd1;
            end
        end
    end

    // Storage carries no reset; contents are only meaningful below level.
    always_ff @(posedge CLK) begin
        if (store_cnt != 2'd0) begin
            buffer[wr_ptr] <= store_b0;
        end
        if (store_cnt == 2'd2) begin
            buffer[wr_ptr_p1] <= store_b1;
        end
    end

    always_comb begin
        if (bypass_active) begin
            prefetchTop = first_byte;
        end else if (level != '0) begin
            prefetchTop = buffer[rd_ptr];
        end else begin
            prefetchTop = 8'h00;
        end
    end

    assign prefetchEmpty            = (level == '0) && !bypass_active;
    assign prefetchTopLinearAddress = top_addr;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: an 8088-style instance (DEPTH=4, 1 byte) and an 8086-style one (DEPTH=6, 2 bytes)
// checked against a byte-queue scoreboard and address model.
module tb_prefetch_queue;

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_wv, a_odd, a_adv, a_fl;
    logic [7:0]  a_d;
    logic [19:0] a_fa;
    logic [7:0]  a_top;
    logic [19:0] a_addr;
    logic        a_empty, a_full;
    logic [2:0]  a_level;

    logic        b_wv, b_odd, b_adv, b_fl;
    logic [15:0] b_d;
    logic [19:0] b_fa;
    logic [7:0]  b_top;
    logic [19:0] b_addr;
    logic        b_empty, b_full;
    logic [2:0]  b_level;

    prefetch_queue #(.DEPTH(4), .BUS_BYTES(1), .RESET_ADDR(20'hFFFF0)) u_a (
        .CLK(CLK), .RESET_n(RESET_n), .wrValid(a_wv), .wrData(a_d), .wrOddStart(a_odd),
        .advanceTop(a_adv), .flush(a_fl), .flushAddr(a_fa), .prefetchTop(a_top),
        .prefetchTopLinearAddress(a_addr), .prefetchEmpty(a_empty), .prefetchFull(a_full),
        .level(a_level)
    );

    prefetch_queue #(.DEPTH(6), .BUS_BYTES(2), .RESET_ADDR(20'hFFFF0)) u_b (
        .CLK(CLK), .RESET_n(RESET_n), .wrValid(b_wv), .wrData(b_d), .wrOddStart(b_odd),
        .advanceTop(b_adv), .flush(b_fl), .flushAddr(b_fa), .prefetchTop(b_top),
        .prefetchTopLinearAddress(b_addr), .prefetchEmpty(b_empty), .prefetchFull(b_full),
        .level(b_level)
    );

`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  sb_q [$];
    logic [19:0] m_addr = 20'hFFFF0;
    bit          cur = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] obs_level();
        return cur ? b_level : a_level;
    endfunction

    function automatic logic [19:0] obs_addr();
        return cur ? b_addr : a_addr;
    endfunction

    function automatic logic [7:0] obs_top();
        return cur ? b_top : a_top;
    endfunction

    task automatic idle_inputs();
        a_wv = 0; a_odd = 0; a_adv = 0; a_fl = 0; a_d = '0; a_fa = '0;
        b_wv = 0; b_odd = 0; b_adv = 0; b_fl = 0; b_d = '0; b_fa = '0;
    endtask

    // One clock cycle on the selected instance; entered and left just after a falling edge.
    task automatic step(input logic wv, input logic [15:0] d, input logic odd,
                        input logic adv, input logic fl, input logic [19:0] fa);
        int unsigned depth, bb, lvl, n;
        logic [7:0]  b0, b1, exp_top, popped;
        logic        exp_full, acc, byp;
        if (!cur) begin
            a_wv = wv; a_d = d[7:0]; a_adv = adv; a_fl = fl; a_fa = fa;
        end else begin
            b_wv = wv; b_d = d; b_odd = odd; b_adv = adv; b_fl = fl; b_fa = fa;
        end
        #1;
        depth    = cur ? 6 : 4;
        bb       = cur ? 2 : 1;
        lvl      = sb_q.size();
        exp_full = (depth - lvl) < bb;
        n        = (bb == 2 && !odd) ? 2 : 1;
        b0       = (bb == 2 && odd) ? d[15:8] : d[7:0];
        b1       = d[15:8];
        acc      = wv && !exp_full && !fl;
        byp      = BYP && (lvl == 0) && acc;
        exp_top  = byp ? b0 : ((lvl != 0) ? sb_q[0] : 8'h00);
        check_eq("full", cur ? b_full : a_full, exp_full);
        check_eq("empty", cur ? b_empty : a_empty, (lvl == 0) && !byp);
        check_eq("top", obs_top(), exp_top);
        check_eq("addr", obs_addr(), m_addr);
        if (fl) begin
            sb_q.delete();
            m_addr = fa;
        end else begin
            if (adv && lvl != 0) begin
                popped = sb_q.pop_front();
                m_addr = m_addr + 20'd1;
            end else if (adv && byp) begin
                m_addr = m_addr + 20'd1;
            end
            if (acc) begin
                if (!(adv && byp)) sb_q.push_back(b0);
                if (n == 2) sb_q.push_back(b1);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
        #1;
        check_eq("level", obs_level(), sb_q.size());
    endtask

    task automatic push(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 20'h0);
    endtask

    task automatic pop();
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 20'h0);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET_n = 0;
        #2;
        RESET_n = 1;
        sb_q.delete();
        m_addr = 20'hFFFF0;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        repeat (2) @(negedge CLK);
        check_eq("rst_a_level", a_level, 3'd0);
        check_eq("rst_a_empty", a_empty, 1'b1);
        check_eq("rst_a_full", a_full, 1'b0);
        check_eq("rst_a_top", a_top, 8'h00);
        check_eq("rst_b_addr", b_addr, 20'hFFFF0);
        RESET_n = 1;
        @(negedge CLK);

        // Asynchronous reset in the middle of a fill
        cur = 0;
        push(16'h0001); push(16'h0002); push(16'h0003);
        check_eq("midfill_level", a_level, 3'd3);
        #2 RESET_n = 0;
        #1;
        check_eq("arst_level", a_level, 3'd0);
        check_eq("arst_empty", a_empty, 1'b1);
        check_eq("arst_addr", a_addr, 20'hFFFF0);
        sb_q.delete();
        m_addr = 20'hFFFF0;
        @(negedge CLK);
        RESET_n = 1;
        @(negedge CLK);

        // 8088 style: fill, overfill, drain, pop on empty
        push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
        check_eq("a_full_at4", a_full, 1'b1);
        push(16'h0055);
        pop(); pop(); pop(); pop();
        check_eq("a_addr_after4", a_addr, 20'hFFFF4);
        pop();

        // Write and pop to an empty queue in the same cycle
        step(1'b1, 16'h007E, 1'b0, 1'b1, 1'b0, 20'h0);
        check_eq("bypass_level", a_level, BYP ? 3'd0 : 3'd1);
        while (sb_q.size() != 0) pop();

        // Flush dominates concurrent write and pop; address wraps past FFFFF
        push(16'h0001); push(16'h0002);
        step(1'b1, 16'h00EE, 1'b0, 1'b1, 1'b1, 20'hFFFFF);
        check_eq("flush_level", a_level, 3'd0);
        check_eq("flush_addr", a_addr, 20'hFFFFF);
        push(16'h009A);
        pop();
        check_eq("wrap_addr", a_addr, 20'h00000);

        // 8086 style instance
        pulse_reset();
        cur = 1;
        push(16'h2211); push(16'h4433);
        check_eq("b_level4", b_level, 3'd4);
        check_eq("b_notfull4", b_full, 1'b0);
        push(16'h6655);
        check_eq("b_full6", b_full, 1'b1);
        pop();
        step(1'b1, 16'h8877, 1'b0, 1'b1, 1'b0, 20'h0);
        check_eq("b_drop_level", b_level, 3'd4);
        step(1'b1, 16'hDDCC, 1'b0, 1'b1, 1'b0, 20'h0);
        while (sb_q.size() != 0) pop();

        // Odd-address fetch after redirect
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 20'h01235);
        step(1'b1, 16'hBBAA, 1'b1, 1'b0, 1'b0, 20'h0);
        check_eq("odd_level", b_level, 3'd1);
        check_eq("odd_top", b_top, 8'hBB);
        check_eq("odd_addr", b_addr, 20'h01235);
        pop();
        step(1'b1, 16'hF0E1, 1'b0, 1'b0, 1'b0, 20'h0);
        pop(); pop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
